// File: rtl/hazard_stall_controller.sv
`timescale 1ns / 1ps
// hazard_stall_controller
// Pipeline sequencing controller for the 5-stage MIPS core. It sits beside the forwarding unit
// and does four jobs:
//   - stalls on RAW hazards that forwarding cannot cover, inserting an ID/EX bubble;
//   - flushes IF/ID when a branch resolves taken;
//   - freezes the whole pipeline while a multi-cycle SRAM access in MEM is outstanding;
//   - counts stall cycles and raises a sticky error when a memory access times out.
// Build option: define FORWARDING_EN when the forwarding paths are present. Only load-use
// dependencies then stall. Without it, every RAW dependency on EXE or MEM stalls.
module hazard_stall_controller #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       i_id_src1,
  input  logic [4:0]       i_id_src2,
  input  logic             i_id_two_src,
  input  logic [4:0]       i_exe_dest,
  input  logic             i_exe_wb_en,
  input  logic             i_exe_mem_r_en,
  input  logic [4:0]       i_mem_dest,
  input  logic             i_mem_wb_en,
  input  logic             i_mem_access_req,
  input  logic             i_mem_ready,
  input  logic             i_branch_taken,
  output logic             o_freeze_all,
  output logic             o_freeze_if_id,
  output logic             o_bubble_id_ex,
  output logic             o_flush_if_id,
  output logic [1:0]       o_ctrl_state,
  output logic [CNT_W-1:0] o_stall_count,
  output logic             o_mem_timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StMemWait = 2'b01,
    StErr     = 2'b10
  } state_e;

  state_e           r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_mem_timeout;

  state_e           w_state_nxt;
  logic [CNT_W-1:0] w_wait_nxt;
  logic [CNT_W-1:0] w_stall_nxt;
  logic             w_timeout_nxt;

  logic w_exe_match;
  logic w_mem_match;
  logic w_hazard;
  logic w_apply;
  logic w_freeze_all;
  logic w_freeze_if_id;
  logic w_bubble_id_ex;
  logic w_flush_if_id;

  // Register 0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic raw_match(input logic [4:0] dest, input logic wb_en,
                                     input logic [4:0] src1, input logic [4:0] src2,
                                     input logic two_src);
    return wb_en && (dest != 5'd0) && ((dest == src1) || (two_src && (dest == src2)));
  endfunction

  assign w_exe_match = raw_match(i_exe_dest, i_exe_wb_en, i_id_src1, i_id_src2, i_id_two_src);
  assign w_mem_match = raw_match(i_mem_dest, i_mem_wb_en, i_id_src1, i_id_src2, i_id_two_src);

`ifdef FORWARDING_EN
  // Forwarding covers everything except a load whose data only arrives after MEM.
  logic w_unused_mem_match;
  assign w_unused_mem_match = w_mem_match;
  assign w_hazard = i_exe_mem_r_en && w_exe_match;
`else
  // No forwarding paths: any producer still in EXE or MEM forces a stall.
  logic w_unused_load;
  assign w_unused_load = i_exe_mem_r_en;
  assign w_hazard = w_exe_match || w_mem_match;
`endif

  // Decide whether the pipeline is frozen for SRAM, or whether branch/hazard rules may act.
  always_comb begin
    w_freeze_all = 1'b0;
    w_apply      = 1'b0;
    case (r_state)
      StRun: begin
        if (i_mem_access_req && !i_mem_ready) begin
          w_freeze_all = 1'b1;
        end else begin
          w_apply = 1'b1;
        end
      end
      StMemWait: begin
        if (!i_mem_ready) begin
          w_freeze_all = 1'b1;
        end else begin
          w_apply = 1'b1;
        end
      end
      StErr: begin
        w_freeze_all = 1'b1;
      end
      default: begin
        w_freeze_all = 1'b1;
      end
    endcase
  end

  // Branch squashes the ID instruction, so its hazard is irrelevant; otherwise stall on hazard.
  always_comb begin
    w_freeze_if_id = 1'b0;
    w_bubble_id_ex = 1'b0;
    w_flush_if_id  = 1'b0;
    if (w_apply) begin
      if (i_branch_taken) begin
        w_flush_if_id  = 1'b1;
        w_bubble_id_ex = 1'b1;
      end else if (w_hazard) begin
        w_freeze_if_id = 1'b1;
        w_bubble_id_ex = 1'b1;
      end
    end
  end

  // Next-state, wait counter, sticky timeout and saturating stall counter.
  always_comb begin
    w_state_nxt   = r_state;
    w_wait_nxt    = r_wait_cnt;
    w_timeout_nxt = r_mem_timeout;
    w_stall_nxt   = r_stall_cnt;
    case (r_state)
      StRun: begin
        if (i_mem_access_req && !i_mem_ready) begin
          w_state_nxt = StMemWait;
          w_wait_nxt  = CNT_ONE;
        end
      end
      StMemWait: begin
        if (i_mem_ready) begin
          w_state_nxt = StRun;
          w_wait_nxt  = '0;
        end else if (r_wait_cnt >= TIMEOUT_VAL) begin
          w_state_nxt   = StErr;
          w_timeout_nxt = 1'b1;
        end else begin
          w_wait_nxt = r_wait_cnt + CNT_ONE;
        end
      end
      StErr: begin
        w_state_nxt = StErr;
      end
      default: begin
        // Unused encoding: park in the error state rather than run unchecked.
        w_state_nxt   = StErr;
        w_timeout_nxt = 1'b1;
      end
    endcase
    if ((w_freeze_all || w_freeze_if_id) && (r_stall_cnt != CNT_MAX)) begin
      w_stall_nxt = r_stall_cnt + CNT_ONE;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StRun;
      r_wait_cnt    <= '0;
      r_stall_cnt   <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_wait_nxt;
      r_stall_cnt   <= w_stall_nxt;
      r_mem_timeout <= w_timeout_nxt;
    end
  end

  // Control outputs are forced low while reset is held, whatever the inputs show.
  assign o_freeze_all   = rst_n && w_freeze_all;
  assign o_freeze_if_id = rst_n && w_freeze_if_id;
  assign o_bubble_id_ex = rst_n && w_bubble_id_ex;
  assign o_flush_if_id  = rst_n && w_flush_if_id;
  assign o_ctrl_state   = r_state;
  assign o_stall_count  = r_stall_cnt;
  assign o_mem_timeout  = r_mem_timeout;

endmodule

// File: tb/tb_hazard_stall_controller.sv
`timescale 1ns / 1ps
// Directed bench for hazard_stall_controller. Main instance uses default parameters; a second
// instance (MEM_TIMEOUT=3, CNT_W=4) covers the timeout path and counter saturation.
module tb_hazard_stall_controller;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_src1, id_src2, exe_dest, mem_dest;
  logic        id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic        mem_access_req, mem_ready, branch_taken;

  logic        freeze_all, freeze_if_id, bubble_id_ex, flush_if_id, mem_timeout;
  logic [1:0]  ctrl_state;
  logic [15:0] stall_count;

  logic        t_freeze_all, t_freeze_if_id, t_bubble_id_ex, t_flush_if_id, t_mem_timeout;
  logic [1:0]  t_ctrl_state;
  logic [3:0]  t_stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_stall_controller u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_id_src1        (id_src1),
    .i_id_src2        (id_src2),
    .i_id_two_src     (id_two_src),
    .i_exe_dest       (exe_dest),
    .i_exe_wb_en      (exe_wb_en),
    .i_exe_mem_r_en   (exe_mem_r_en),
    .i_mem_dest       (mem_dest),
    .i_mem_wb_en      (mem_wb_en),
    .i_mem_access_req (mem_access_req),
    .i_mem_ready      (mem_ready),
    .i_branch_taken   (branch_taken),
    .o_freeze_all     (freeze_all),
    .o_freeze_if_id   (freeze_if_id),
    .o_bubble_id_ex   (bubble_id_ex),
    .o_flush_if_id    (flush_if_id),
    .o_ctrl_state     (ctrl_state),
    .o_stall_count    (stall_count),
    .o_mem_timeout    (mem_timeout)
  );

  hazard_stall_controller #(
    .MEM_TIMEOUT (3),
    .CNT_W       (4)
  ) u_dut_to (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_id_src1        (id_src1),
    .i_id_src2        (id_src2),
    .i_id_two_src     (id_two_src),
    .i_exe_dest       (exe_dest),
    .i_exe_wb_en      (exe_wb_en),
    .i_exe_mem_r_en   (exe_mem_r_en),
    .i_mem_dest       (mem_dest),
    .i_mem_wb_en      (mem_wb_en),
    .i_mem_access_req (mem_access_req),
    .i_mem_ready      (mem_ready),
    .i_branch_taken   (branch_taken),
    .o_freeze_all     (t_freeze_all),
    .o_freeze_if_id   (t_freeze_if_id),
    .o_bubble_id_ex   (t_bubble_id_ex),
    .o_flush_if_id    (t_flush_if_id),
    .o_ctrl_state     (t_ctrl_state),
    .o_stall_count    (t_stall_count),
    .o_mem_timeout    (t_mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    id_src1 = 5'd0; id_src2 = 5'd0; id_two_src = 1'b0;
    exe_dest = 5'd0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    mem_dest = 5'd0; mem_wb_en = 1'b0;
    mem_access_req = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
  endtask

  // Load in EXE writing r5, ID reads r5.
  task automatic drive_load_use();
    exe_mem_r_en = 1'b1; exe_wb_en = 1'b1; exe_dest = 5'd5; id_src1 = 5'd5;
  endtask

  // Leaves the bench at a falling edge with reset released and inputs idle.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    drive_idle();
    #1 rst_n = 1'b0;
    drive_load_use();
    mem_access_req = 1'b1; branch_taken = 1'b1;
    #2;
    n_tests++;
    if ({freeze_all, freeze_if_id, bubble_id_ex, flush_if_id} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_ctrl: got %b want 0000",
               {freeze_all, freeze_if_id, bubble_id_ex, flush_if_id});
    end
    n_tests++;
    if (ctrl_state !== 2'b00 || mem_timeout !== 1'b0) begin
      n_fail++; $display("FAIL rst_state: got %b/%b want 00/0", ctrl_state, mem_timeout);
    end
    @(posedge clk); #1;
    n_tests++;
    if (stall_count !== 16'd0) begin
      n_fail++; $display("FAIL rst_count: got %0d want 0", stall_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_idle();
    #2;
    n_tests++;
    if (ctrl_state !== 2'b00 || freeze_all !== 1'b0) begin
      n_fail++; $display("FAIL rst_release: got %b/%b want 00/0", ctrl_state, freeze_all);
    end
  endtask

  task automatic test_hazard();
    int   exp_cnt;
    logic exp;
    do_reset();
    exp_cnt = 0;
    // Load-use stalls in both configurations.
    drive_load_use(); #2;
    n_tests++;
    if ({freeze_if_id, bubble_id_ex, flush_if_id, freeze_all} !== 4'b1100) begin
      n_fail++; $display("FAIL hz_load_use: got %b want 1100",
                         {freeze_if_id, bubble_id_ex, flush_if_id, freeze_all});
    end
    exp_cnt++;
    @(negedge clk); drive_idle(); #2;
    n_tests++;
    if (freeze_if_id !== 1'b0 || stall_count !== 16'(exp_cnt)) begin
      n_fail++; $display("FAIL hz_one_cycle: got %b/%0d want 0/%0d",
                         freeze_if_id, stall_count, exp_cnt);
    end
    // ALU result in EXE: forwarded when forwarding exists.
    @(negedge clk); drive_load_use(); exe_mem_r_en = 1'b0; #2;
    exp = !FWD;
    n_tests++;
    if (freeze_if_id !== exp || bubble_id_ex !== exp) begin
      n_fail++; $display("FAIL hz_exe_alu: got %b%b want %b%b",
                         freeze_if_id, bubble_id_ex, exp, exp);
    end
    if (exp) exp_cnt++;
    // Destination r0 never stalls.
    @(negedge clk); drive_load_use(); exe_dest = 5'd0; id_src1 = 5'd0; mem_wb_en = 1'b1; #2;
    n_tests++;
    if (freeze_if_id !== 1'b0) begin
      n_fail++; $display("FAIL hz_r0: got %b want 0", freeze_if_id);
    end
    // src2 only counts when the instruction reads it.
    @(negedge clk); drive_idle(); drive_load_use(); exe_dest = 5'd9; id_src1 = 5'd3;
    id_src2 = 5'd9; #2;
    n_tests++;
    if (freeze_if_id !== 1'b0) begin
      n_fail++; $display("FAIL hz_src2_unused: got %b want 0", freeze_if_id);
    end
    @(negedge clk); id_two_src = 1'b1; #2;
    n_tests++;
    if (freeze_if_id !== 1'b1 || bubble_id_ex !== 1'b1) begin
      n_fail++; $display("FAIL hz_src2: got %b%b want 11", freeze_if_id, bubble_id_ex);
    end
    exp_cnt++;
    // Producer in MEM.
    @(negedge clk); drive_idle(); mem_dest = 5'd7; mem_wb_en = 1'b1; id_src1 = 5'd7; #2;
    exp = !FWD;
    n_tests++;
    if (freeze_if_id !== exp) begin
      n_fail++; $display("FAIL hz_mem: got %b want %b", freeze_if_id, exp);
    end
    if (exp) exp_cnt++;
    // No writeback, no dependency.
    @(negedge clk); drive_idle(); drive_load_use(); exe_wb_en = 1'b0; #2;
    n_tests++;
    if (freeze_if_id !== 1'b0) begin
      n_fail++; $display("FAIL hz_no_wb: got %b want 0", freeze_if_id);
    end
    @(negedge clk); drive_idle(); #2;
    n_tests++;
    if (stall_count !== 16'(exp_cnt)) begin
      n_fail++; $display("FAIL hz_count: got %0d want %0d", stall_count, exp_cnt);
    end
  endtask

  task automatic test_branch();
    do_reset();
    drive_load_use(); branch_taken = 1'b1; #2;
    n_tests++;
    if ({flush_if_id, bubble_id_ex, freeze_if_id, freeze_all} !== 4'b1100) begin
      n_fail++; $display("FAIL br_hazard: got %b want 1100",
                         {flush_if_id, bubble_id_ex, freeze_if_id, freeze_all});
    end
    @(negedge clk); drive_idle(); branch_taken = 1'b1; #2;
    n_tests++;
    if ({flush_if_id, bubble_id_ex} !== 2'b11) begin
      n_fail++; $display("FAIL br_plain: got %b want 11", {flush_if_id, bubble_id_ex});
    end
    @(negedge clk); drive_idle(); #2;
    n_tests++;
    if (stall_count !== 16'd0 || flush_if_id !== 1'b0) begin
      n_fail++; $display("FAIL br_count: got %0d/%b want 0/0", stall_count, flush_if_id);
    end
  endtask

  task automatic test_mem_wait();
    logic [1:0] exp_st;
    do_reset();
    // Single-cycle access never freezes.
    mem_access_req = 1'b1; mem_ready = 1'b1; #2;
    n_tests++;
    if (freeze_all !== 1'b0) begin
      n_fail++; $display("FAIL mw_single: got %b want 0", freeze_all);
    end
    @(negedge clk); drive_idle(); #2;
    n_tests++;
    if (ctrl_state !== 2'b00 || stall_count !== 16'd0) begin
      n_fail++; $display("FAIL mw_single_state: got %b/%0d want 00/0", ctrl_state, stall_count);
    end
    // Four waiting cycles, ready on the fifth.
    mem_access_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      exp_st = (i == 0) ? 2'b00 : 2'b01;
      n_tests++;
      if (freeze_all !== 1'b1 || ctrl_state !== exp_st) begin
        n_fail++; $display("FAIL mw_wait c%0d: got %b/%b want 1/%b",
                           i, freeze_all, ctrl_state, exp_st);
      end
      @(negedge clk);
    end
    mem_ready = 1'b1; #2;
    n_tests++;
    if (freeze_all !== 1'b0 || ctrl_state !== 2'b01) begin
      n_fail++; $display("FAIL mw_release: got %b/%b want 0/01", freeze_all, ctrl_state);
    end
    @(negedge clk); drive_idle(); #2;
    n_tests++;
    if (ctrl_state !== 2'b00 || stall_count !== 16'd4) begin
      n_fail++; $display("FAIL mw_done: got %b/%0d want 00/4", ctrl_state, stall_count);
    end
  endtask

  task automatic test_branch_in_wait();
    do_reset();
    drive_load_use(); branch_taken = 1'b1; mem_access_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #2;
      n_tests++;
      if ({freeze_all, flush_if_id, bubble_id_ex, freeze_if_id} !== 4'b1000) begin
        n_fail++; $display("FAIL bw_masked c%0d: got %b want 1000", i,
                           {freeze_all, flush_if_id, bubble_id_ex, freeze_if_id});
      end
      @(negedge clk);
    end
    mem_ready = 1'b1; #2;
    n_tests++;
    if ({freeze_all, flush_if_id, bubble_id_ex, freeze_if_id} !== 4'b0110) begin
      n_fail++; $display("FAIL bw_release: got %b want 0110",
                         {freeze_all, flush_if_id, bubble_id_ex, freeze_if_id});
    end
    @(negedge clk); drive_idle(); #2;
    n_tests++;
    if (ctrl_state !== 2'b00 || stall_count !== 16'd2) begin
      n_fail++; $display("FAIL bw_done: got %b/%0d want 00/2", ctrl_state, stall_count);
    end
  endtask

  task automatic test_timeout();
    logic [1:0] exp_st;
    do_reset();
    mem_access_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      exp_st = (i == 0) ? 2'b00 : 2'b01;
      n_tests++;
      if (t_ctrl_state !== exp_st || t_mem_timeout !== 1'b0 || t_freeze_all !== 1'b1) begin
        n_fail++; $display("FAIL to_wait c%0d: got %b/%b/%b want %b/0/1", i,
                           t_ctrl_state, t_mem_timeout, t_freeze_all, exp_st);
      end
      @(negedge clk);
    end
    #2;
    n_tests++;
    if (t_ctrl_state !== 2'b10 || t_mem_timeout !== 1'b1 || t_stall_count !== 4'd4) begin
      n_fail++; $display("FAIL to_err: got %b/%b/%0d want 10/1/4",
                         t_ctrl_state, t_mem_timeout, t_stall_count);
    end
    // Error state ignores ready, branch and hazards.
    @(negedge clk); drive_idle(); drive_load_use(); mem_ready = 1'b1; branch_taken = 1'b1; #2;
    n_tests++;
    if ({t_freeze_all, t_flush_if_id, t_bubble_id_ex, t_freeze_if_id} !== 4'b1000 ||
        t_ctrl_state !== 2'b10) begin
      n_fail++; $display("FAIL to_hold: got %b/%b want 1000/10",
                         {t_freeze_all, t_flush_if_id, t_bubble_id_ex, t_freeze_if_id},
                         t_ctrl_state);
    end
    repeat (20) @(negedge clk);
    #2;
    n_tests++;
    if (t_stall_count !== 4'hF || t_mem_timeout !== 1'b1 || t_ctrl_state !== 2'b10) begin
      n_fail++; $display("FAIL to_saturate: got %0d/%b/%b want 15/1/10",
                         t_stall_count, t_mem_timeout, t_ctrl_state);
    end
    do_reset(); #2;
    n_tests++;
    if (t_ctrl_state !== 2'b00 || t_mem_timeout !== 1'b0 || t_stall_count !== 4'd0) begin
      n_fail++; $display("FAIL to_reset: got %b/%b/%0d want 00/0/0",
                         t_ctrl_state, t_mem_timeout, t_stall_count);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    mem_access_req = 1'b1; mem_ready = 1'b0;
    @(negedge clk); @(negedge clk); #2;
    n_tests++;
    if (ctrl_state !== 2'b01 || stall_count !== 16'd2) begin
      n_fail++; $display("FAIL rm_pre: got %b/%0d want 01/2", ctrl_state, stall_count);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (ctrl_state !== 2'b00 || stall_count !== 16'd0 || freeze_all !== 1'b0) begin
      n_fail++; $display("FAIL rm_async: got %b/%0d/%b want 00/0/0",
                         ctrl_state, stall_count, freeze_all);
    end
    @(negedge clk); rst_n = 1'b1; drive_idle(); #2;
    n_tests++;
    if (ctrl_state !== 2'b00 || freeze_all !== 1'b0) begin
      n_fail++; $display("FAIL rm_after: got %b/%b want 00/0", ctrl_state, freeze_all);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    exe_mem_r_en = 1'b1; exe_wb_en = 1'b1; exe_dest = 5'd3; id_src1 = 5'd3; #2;
    n_tests++;
    if ({freeze_if_id, bubble_id_ex} !== 2'b11) begin
      n_fail++; $display("FAIL bb_first: got %b want 11", {freeze_if_id, bubble_id_ex});
    end
    @(negedge clk); exe_dest = 5'd4; id_src1 = 5'd1; id_src2 = 5'd4; id_two_src = 1'b1; #2;
    n_tests++;
    if ({freeze_if_id, bubble_id_ex} !== 2'b11) begin
      n_fail++; $display("FAIL bb_second: got %b want 11", {freeze_if_id, bubble_id_ex});
    end
    @(negedge clk); branch_taken = 1'b1; #2;
    n_tests++;
    if ({flush_if_id, freeze_if_id} !== 2'b10) begin
      n_fail++; $display("FAIL bb_branch: got %b want 10", {flush_if_id, freeze_if_id});
    end
    @(negedge clk); drive_idle(); #2;
    n_tests++;
    if (stall_count !== 16'd2) begin
      n_fail++; $display("FAIL bb_count: got %0d want 2", stall_count);
    end
  endtask

  initial begin
    test_reset();
    test_hazard();
    test_branch();
    test_mem_wait();
    test_branch_in_wait();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
